// File: rtl/aes_decrypt_top.sv
// aes_decrypt_top
//   Iterative AES-128 inverse cipher, one round per clock.
//   A start in IDLE captures the ciphertext and key. The next 10 cycles expand
//   the forward key schedule into an 11-entry key file. Then come one INIT
//   cycle, 9 inverse rounds and one FINAL cycle. done pulses with the plaintext.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request, sampled only in IDLE
//   cipher_text [127:0] ciphertext, byte 0 = bits [127:120], column-major
//   cipher_key  [127:0] AES-128 key, same byte order
//   plain_text  [127:0] working state; holds the plaintext after done
//   done                one-cycle completion pulse
//   completed_round[9:0] one-hot round marker (bit 0 = initial AddRoundKey)
module aes_decrypt_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] cipher_text,
    input  logic [127:0] cipher_key,
    output logic [127:0] plain_text,
    output logic         done,
    output logic [9:0]   completed_round
);
    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Undo the affine transform first, then invert in GF(2^8).
    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // InvShiftRows then InvSubBytes: row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = sbox_inv(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0: return 8'h01;
            4'd1: return 8'h02;
            4'd2: return 8'h04;
            4'd3: return 8'h08;
            4'd4: return 8'h10;
            4'd5: return 8'h20;
            4'd6: return 8'h40;
            4'd7: return 8'h80;
            4'd8: return 8'h1b;
            4'd9: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = rk;
        t  = {sbox_fwd(w3[23:16]), sbox_fwd(w3[15:8]), sbox_fwd(w3[7:0]), sbox_fwd(w3[31:24])}
             ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [127:0]         st_q, st_d;
    logic [10:0][127:0]   rk_q, rk_d;
    logic                 done_q, done_d;
    logic [9:0]           cr_q, cr_d;
    logic [127:0]         iss;
    logic [3:0]           key_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        rk_d    = rk_q;
        done_d  = 1'b0;
        cr_d    = '0;
        iss     = inv_shift_sub(st_q);   // shared by ROUND and FINAL
        key_idx = 4'd10 - cnt_q;
        case (state_q)
            IDLE: if (start) begin
                st_d    = cipher_text;
                rk_d[0] = cipher_key;
                cnt_d   = 4'd0;
                state_d = KEYEXP;
            end
            KEYEXP: begin
                // cnt_q = 0..9 derives rk[cnt_q+1]
                rk_d[cnt_q + 4'd1] = key_next(rk_q[cnt_q], rcon(cnt_q));
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) state_d = INIT;
            end
            INIT: begin
                st_d    = st_q ^ rk_q[10];
                cr_d    = 10'd1;
                cnt_d   = 4'd1;
                state_d = ROUND;
            end
            ROUND: begin
                // round k uses rk[10-k]
                st_d  = inv_mix(iss ^ rk_q[key_idx]);
                cr_d  = 10'd1 << cnt_q;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) state_d = FINAL;
            end
            FINAL: begin
                st_d    = iss ^ rk_q[0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
            rk_q    <= '0;
            done_q  <= 1'b0;
            cr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            done_q  <= done_d;
            cr_q    <= cr_d;
        end
    end

    assign plain_text      = st_q;
    assign done            = done_q;
    assign completed_round = cr_q;
endmodule
